// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter plot port among NUM_REQ drawing engines.
// Define VGA_ARB_CLIP_EN to drop (and count) pixels outside X_MAX/Y_MAX.
module vga_plot_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ*8-1:0] in_x,
  input  logic [NUM_REQ*7-1:0] in_y,
  input  logic [NUM_REQ*3-1:0] in_colour,
  input  logic [NUM_REQ-1:0]   in_plot,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic [15:0]          clip_count
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t state, state_next;
  logic [1:0] owner_next, ptr, ptr_next, winner;
  logic found;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [2:0] cand;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic sel_plot, sel_req, off_screen;

  // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    req_rot = {req, req} >> ptr;
    winner  = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        winner = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    sel_req    = 1'b0;
    gnt        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 2'(i)) begin
        sel_x      = in_x[8*i +: 8];
        sel_y      = in_y[7*i +: 7];
        sel_colour = in_colour[3*i +: 3];
        sel_plot   = in_plot[i];
        sel_req    = req[i];
        gnt[i]     = (state == GRANT);
      end
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          owner_next = winner;
        end
      end
      GRANT: begin
        if (!sel_req) begin
          state_next = RELEASE;
          ptr_next   = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
        end
      end
      RELEASE: begin
        if (found) begin
          state_next = GRANT;
          owner_next = winner;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      ptr   <= ptr_next;
    end
  end

  assign busy = (state != IDLE);

`ifdef VGA_ARB_CLIP_EN
  assign off_screen = (sel_x > 8'(X_MAX)) || (sel_y > 7'(Y_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (state == GRANT && sel_plot && off_screen && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  logic [14:0] unused_limits;
  assign unused_limits = {8'(X_MAX), 7'(Y_MAX)};
  assign off_screen    = 1'b0;
  assign clip_count    = '0;
`endif

  // Coordinates load on every GRANT edge, so the pixel alongside the req drop still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (state == GRANT) begin
      vga_x      <= sel_x;
      vga_y      <= sel_y;
      vga_colour <= sel_colour;
      vga_plot   <= sel_plot && !off_screen;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

endmodule
